crtc_gen2: RTL and testbench

CRTC_GEN2 -- requirements
Module: crtc_gen2

---
 rtl/crtc_gen2_if.sv | 17 +
 rtl/crtc_gen2.sv | 205 ++++++++++++++++++++
 tb/tb_crtc_gen2.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crtc_gen2_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crtc_gen2_if : CPU register bus between host and the CRTC          |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
interface crtc_gen2_if;
  logic       cs;
  logic       a0;
  logic       write;
  logic       read;
  logic [7:0] bus;
  logic [7:0] bus_out;

  modport master (output cs, a0, write, read, bus, input bus_out);
  modport slave  (input cs, a0, write, read, bus, output bus_out);
endinterface
`default_nettype wire

// File: rtl/crtc_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | crtc_gen2 : 6845-style CRT controller (timing, addressing, cursor) |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module crtc_gen2 #(
  parameter int          MA_W        = 14,
  parameter int          RA_W        = 5,
  parameter logic [7:0]  R0_INIT     = 8'd97,
  parameter logic [7:0]  R1_INIT     = 8'd80,
  parameter logic [7:0]  R2_INIT     = 8'd82,
  parameter logic [7:0]  R3_INIT     = 8'hF5,
  parameter logic [7:0]  R4_INIT     = 8'd25,
  parameter logic [7:0]  R5_INIT     = 8'd6,
  parameter logic [7:0]  R6_INIT     = 8'd25,
  parameter logic [7:0]  R7_INIT     = 8'd25,
  parameter logic [7:0]  R8_INIT     = 8'd0,
  parameter logic [7:0]  R9_INIT     = 8'd13,
  parameter logic [7:0]  R10_INIT    = 8'd11,
  parameter logic [7:0]  R11_INIT    = 8'd12,
  parameter logic [15:0] CURSOR_INIT = 16'd92
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              divclk,
  input  wire              lock,
  input  wire              lpen_stb,
  crtc_gen2_if.slave       bif,
  output logic             hsync,
  output logic             vsync,
  output logic             display_enable,
  output logic             cursor,
  output logic             line_reset,
  output logic             lpen_valid,
  output logic [MA_W-1:0]  mem_addr,
  output logic [RA_W-1:0]  row_addr
);

  // Implemented bits per register; the rest are never stored and read as 0
  localparam logic [7:0] c_mask [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h1F, 8'h7F, 8'h7F,
                                         8'hFF, 8'h1F, 8'h7F, 8'h1F, 8'h3F, 8'hFF, 8'h3F, 8'hFF};
  localparam logic [7:0] c_init [16] = '{R0_INIT, R1_INIT, R2_INIT, R3_INIT, R4_INIT, R5_INIT,
                                         R6_INIT, R7_INIT, R8_INIT, R9_INIT, R10_INIT, R11_INIT,
                                         8'h00, 8'h00, {2'b00, CURSOR_INIT[13:8]}, CURSOR_INIT[7:0]};

  logic [4:0]      r_index;
  logic [7:0]      r_regs [16];
  logic [7:0]      r_h_count;
  logic            r_hdisp, r_vdisp, r_hsync, r_vsync;
  logic [4:0]      r_hs_cnt, r_vs_cnt, r_blink;
  logic [6:0]      r_row;
  logic [RA_W-1:0] r_row_addr;
  logic [MA_W-1:0] r_row_base, r_lpen_addr;
  logic            r_lpen_prev, r_lpen_valid;

  logic            w_reg_wr_ok, w_h_end, w_h_wrap, w_line, w_last_sl, w_adj_last;
  logic            w_last_row, w_frame_end, w_row_end, w_mode_on;
  logic [7:0]      w_h_inc;
  logic [6:0]      w_row_inc, w_ra7;
  logic [5:0]      w_ra6;
  logic [4:0]      w_hs_w, w_vs_w;
  logic [MA_W-1:0] w_start, w_cur_addr;

  // ---------------- register file ----------------
  assign w_reg_wr_ok = !r_index[4] && (r_index[3:0] != 4'd8) && !(lock && (r_index[3:0] <= 4'd9));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= c_init[i] & c_mask[i];
    end else if (bif.cs && bif.write) begin
      if (!bif.a0)
        r_index <= bif.bus[4:0];
      else if (w_reg_wr_ok)
        r_regs[r_index[3:0]] <= bif.bus & c_mask[r_index[3:0]];
    end
  end

  always_comb begin
    bif.bus_out = 8'h00;
    if (!r_index[4])           bif.bus_out = r_regs[r_index[3:0]];
    else if (r_index == 5'd16) bif.bus_out = 8'(r_lpen_addr >> 8);
    else if (r_index == 5'd17) bif.bus_out = r_lpen_addr[7:0];
  end

  // ---------------- horizontal ----------------
  assign w_h_inc    = r_h_count + 8'd1;
  assign w_h_end    = (r_h_count == r_regs[0]);
  // A counter pushed past R0 by a mid-line write rolls over at 255 instead
  assign w_h_wrap   = w_h_end || (r_h_count == 8'hFF);
  assign w_line     = divclk && w_h_wrap;
  assign line_reset = w_h_end;
  assign w_hs_w     = (r_regs[3][3:0] == 4'd0) ? 5'd16 : {1'b0, r_regs[3][3:0]};
  assign w_vs_w     = (r_regs[3][7:4] == 4'd0) ? 5'd16 : {1'b0, r_regs[3][7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_count <= '0;
      r_hdisp   <= 1'b1;
      r_hsync   <= 1'b0;
      r_hs_cnt  <= '0;
    end else if (divclk) begin
      r_h_count <= w_h_end ? 8'd0 : w_h_inc;
      if (w_h_wrap)                   r_hdisp <= 1'b1;
      else if (w_h_inc == r_regs[1])  r_hdisp <= 1'b0;
      if (w_h_inc == r_regs[2]) begin
        r_hsync  <= 1'b1;
        r_hs_cnt <= w_hs_w;
      end else if (r_hsync) begin
        if (r_hs_cnt == 5'd1) r_hsync <= 1'b0;
        r_hs_cnt <= r_hs_cnt - 5'd1;
      end
    end
  end

  // ---------------- vertical ----------------
  assign w_ra7       = 7'(r_row_addr);
  assign w_last_sl   = (w_ra7 == 7'(r_regs[9][4:0]));
  assign w_adj_last  = (w_ra7 == (7'(r_regs[9][4:0]) + 7'(r_regs[5][4:0])));
  assign w_last_row  = (r_row == r_regs[4][6:0]);
  assign w_frame_end = w_last_row && w_adj_last;
  assign w_row_end   = !w_last_row && w_last_sl;
  assign w_row_inc   = r_row + 7'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row      <= '0;
      r_row_addr <= '0;
      r_row_base <= '0;
      r_vdisp    <= 1'b1;
      r_vsync    <= 1'b0;
      r_vs_cnt   <= '0;
      r_blink    <= '0;
    end else if (w_line) begin
      if (w_frame_end) begin
        r_row      <= '0;
        r_row_addr <= '0;
        r_row_base <= '0;
        r_vdisp    <= 1'b1;
        r_blink    <= r_blink + 5'd1;
      end else begin
        if (w_row_end) begin
          r_row      <= w_row_inc;
          r_row_addr <= '0;
          if (w_row_inc == r_regs[6][6:0]) r_vdisp <= 1'b0;
        end else begin
          r_row_addr <= r_row_addr + RA_W'(1);
        end
        if (w_last_sl) r_row_base <= r_row_base + MA_W'(r_regs[1]);
      end
      if (r_vsync) begin
        if (r_vs_cnt == 5'd1) r_vsync <= 1'b0;
        r_vs_cnt <= r_vs_cnt - 5'd1;
      end else if (w_row_end && (w_row_inc == r_regs[7][6:0])) begin
        r_vsync  <= 1'b1;
        r_vs_cnt <= w_vs_w;
      end
    end
  end

  // ---------------- addressing and cursor ----------------
  assign w_start    = MA_W'({r_regs[8][7:6], r_regs[12][5:0], r_regs[13]});
  assign w_cur_addr = MA_W'({r_regs[8][7:6], r_regs[14][5:0], r_regs[15]});
  assign mem_addr   = w_start + r_row_base + MA_W'(r_h_count);
  assign row_addr   = r_row_addr;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign display_enable = r_hdisp && r_vdisp;
  assign w_ra6      = 6'(r_row_addr);

  always_comb begin
    w_mode_on = 1'b1;
    case (r_regs[10][6:5])
      2'b00:   w_mode_on = 1'b1;
      2'b01:   w_mode_on = 1'b0;
      2'b10:   w_mode_on = r_blink[3];
      default: w_mode_on = r_blink[4];
    endcase
  end

  assign cursor = (mem_addr == w_cur_addr) && (w_ra6 >= 6'(r_regs[10][4:0])) &&
                  (w_ra6 <= 6'(r_regs[11][4:0])) && display_enable && w_mode_on;

  // ---------------- light pen ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lpen_prev  <= 1'b0;
      r_lpen_addr  <= '0;
      r_lpen_valid <= 1'b0;
    end else begin
      r_lpen_prev <= lpen_stb;
      // A fresh strobe beats a simultaneous low-byte read
      if (lpen_stb && !r_lpen_prev) begin
        r_lpen_addr  <= mem_addr;
        r_lpen_valid <= 1'b1;
      end else if (bif.cs && bif.read && bif.a0 && (r_index == 5'd17)) begin
        r_lpen_valid <= 1'b0;
      end
    end
  end

  assign lpen_valid = r_lpen_valid;

endmodule
`default_nettype wire

// File: tb/tb_crtc_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_crtc_gen2 : scoreboard bench with a frame-position video model  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_crtc_gen2;

  logic        clk = 1'b0;
  logic        rst, divclk, lock, lpen_stb;
  logic        hsync, vsync, display_enable, cursor, line_reset, lpen_valid;
  logic [13:0] mem_addr;
  logic [4:0]  row_addr;

  crtc_gen2_if bif();

  crtc_gen2 dut (
    .clk(clk), .rst(rst), .divclk(divclk), .lock(lock), .lpen_stb(lpen_stb),
    .bif(bif), .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
    .cursor(cursor), .line_reset(line_reset), .lpen_valid(lpen_valid),
    .mem_addr(mem_addr), .row_addr(row_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, vs, de, cur, lr;
    logic [13:0] ma;
    logic [4:0]  ra;
  } vid_t;

  vid_t       vid_q[$];
  int         tq[$];
  logic [7:0] rd_q[$];
  int         regm[16];
  int         t_char;
  int         n_tests, n_fail;
  vid_t       e_v, g_v;
  int         e_t;
  logic [7:0] e_b;

  function automatic void set_defaults();
    regm = '{97, 80, 82, 245, 25, 6, 25, 25, 0, 13, 11, 12, 0, 0, 0, 92};
  endfunction

  // Expected outputs after t character clocks, derived from frame geometry
  function automatic vid_t model(int t);
    vid_t m;
    int p, lpr, f, h, la, fr, l, row, ra, base, hw, vw, ma, ca;
    bit on;
    p   = regm[0] + 1;
    lpr = regm[9] + 1;
    f   = regm[4] * lpr + regm[9] + regm[5] + 1;
    h   = t % p;
    la  = t / p;
    fr  = la / f;
    l   = la % f;
    row = l / lpr;
    if (row > regm[4]) row = regm[4];
    ra   = l - row * lpr;
    base = regm[1] * (row + (((row == regm[4]) && (ra > regm[9])) ? 1 : 0));
    hw   = ((regm[3] & 15) == 0) ? 16 : (regm[3] & 15);
    vw   = ((regm[3] >> 4) == 0) ? 16 : (regm[3] >> 4);
    ma   = ((regm[12] & 63) * 256 + regm[13] + base + h) % 16384;
    ca   = (regm[14] & 63) * 256 + regm[15];
    case ((regm[10] >> 5) & 3)
      0:       on = 1'b1;
      1:       on = 1'b0;
      2:       on = ((fr % 32) / 8) % 2 == 1;
      default: on = ((fr % 32) / 16) == 1;
    endcase
    m.hs  = ((h - regm[2] + p) % p) < hw;
    m.vs  = ((l - regm[7] * lpr + f) % f) < vw;
    m.de  = (h < regm[1]) && (row < regm[6]);
    m.lr  = (h == regm[0]);
    m.ma  = 14'(ma);
    m.ra  = 5'(ra);
    m.cur = (ma == ca) && (ra >= (regm[10] & 31)) && (ra <= (regm[11] & 31)) && m.de && on;
    return m;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents video or read data
  always @(negedge clk) begin
    if (vid_q.size() > 0) begin
      e_v = vid_q.pop_front();
      e_t = tq.pop_front();
      g_v = {hsync, vsync, display_enable, cursor, line_reset, mem_addr, row_addr};
      n_tests++;
      if (g_v !== e_v) begin
        n_fail++;
        $display("FAIL video t=%0d: got hs%b vs%b de%b cur%b lr%b ma%h ra%0d expected hs%b vs%b de%b cur%b lr%b ma%h ra%0d",
                 e_t, g_v.hs, g_v.vs, g_v.de, g_v.cur, g_v.lr, g_v.ma, g_v.ra,
                 e_v.hs, e_v.vs, e_v.de, e_v.cur, e_v.lr, e_v.ma, e_v.ra);
      end
    end
    if (bif.cs && bif.read) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL read: unexpected strobe got %h expected none", bif.bus_out);
      end else begin
        e_b = rd_q.pop_front();
        if (bif.bus_out !== e_b) begin
          n_fail++;
          $display("FAIL read idx %0d: got %h expected %h", dut.r_index, bif.bus_out, e_b);
        end
      end
    end
  end

  task automatic bus_cycle(bit a0_v, bit wr, bit rd, logic [7:0] d);
    bif.cs = 1'b1; bif.a0 = a0_v; bif.write = wr; bif.read = rd; bif.bus = d;
    @(negedge clk); #1;
    bif.cs = 1'b0; bif.write = 1'b0; bif.read = 1'b0;
  endtask

  task automatic wr_reg(int idx, logic [7:0] v);
    bus_cycle(1'b0, 1'b1, 1'b0, 8'(idx));
    bus_cycle(1'b1, 1'b1, 1'b0, v);
    if (idx < 16 && idx != 8 && !(lock && idx <= 9))
      regm[idx] = (idx == 12 || idx == 14) ? int'(v & 8'h3F) : int'(v);
  endtask

  task automatic rd_reg(int idx, logic [7:0] exp);
    bus_cycle(1'b0, 1'b1, 1'b0, 8'(idx));
    rd_q.push_back(exp);
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic reset_dut();
    rst = 1'b1; divclk = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    set_defaults();
    t_char = 0;
    @(negedge clk); #1;
  endtask

  task automatic run_chars(int target, int pct);
    int cyc;
    cyc = 0;
    while (t_char < target && cyc < 4 * target + 100) begin
      divclk = ($urandom_range(0, 99) < pct);
      if (divclk) t_char++;
      vid_q.push_back(model(t_char));
      tq.push_back(t_char);
      cyc++;
      @(negedge clk); #1;
    end
    divclk = 1'b0;
    check("run reached target", 32'(t_char), 32'(target));
  endtask

  int cfg[16];
  int opts[10];
  int idx;
  logic [7:0] v;

  initial begin
    rst = 1'b1; divclk = 1'b0; lock = 1'b0; lpen_stb = 1'b0;
    bif.cs = 1'b0; bif.a0 = 1'b0; bif.write = 1'b0; bif.read = 1'b0; bif.bus = 8'h00;
    n_tests = 0; n_fail = 0; t_char = 0;
    set_defaults();
    repeat (3) @(negedge clk);
    #1;
    check("rst hsync", 32'(hsync), 0);
    check("rst vsync", 32'(vsync), 0);
    check("rst lpen_valid", 32'(lpen_valid), 0);
    check("rst display_enable", 32'(display_enable), 1);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst row_addr", 32'(row_addr), 0);
    check("rst cursor", 32'(cursor), 0);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 18; i++) rd_reg(i, (i < 16) ? 8'(regm[i]) : 8'h00);
    rd_reg(25, 8'h00);

    // Lock protects R0..R9 only
    lock = 1'b1;
    wr_reg(0, 8'd50);
    rd_reg(0, 8'(regm[0]));
    wr_reg(12, 8'd1);
    rd_reg(12, 8'(regm[12]));
    lock = 1'b0;
    wr_reg(8, 8'hFF);
    rd_reg(8, 8'h00);

    // Light pen at address 0x0123 with counters frozen
    wr_reg(13, 8'h23);
    check("lpen mem_addr", 32'(mem_addr), 32'h0123);
    lpen_stb = 1'b1; @(negedge clk); #1; lpen_stb = 1'b0;
    @(negedge clk); #1;
    check("lpen_valid set", 32'(lpen_valid), 1);
    rd_reg(16, 8'h01);
    check("lpen_valid after R16 read", 32'(lpen_valid), 1);
    rd_reg(17, 8'h23);
    check("lpen_valid cleared", 32'(lpen_valid), 0);
    bus_cycle(1'b0, 1'b1, 1'b0, 8'd17);
    lpen_stb = 1'b1;
    rd_q.push_back(8'h23);
    bus_cycle(1'b1, 1'b0, 1'b1, 8'h00);
    lpen_stb = 1'b0;
    check("strobe beats read", 32'(lpen_valid), 1);

    // Random register writes with random lock
    opts = '{0, 1, 2, 3, 8, 12, 13, 14, 15, 20};
    for (int k = 0; k < 16; k++) begin
      idx = opts[$urandom_range(0, 9)];
      if (idx == 20) idx = 18 + $urandom_range(0, 13);
      lock = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      wr_reg(idx, v);
      rd_reg(idx, (idx < 16) ? 8'(regm[idx]) : 8'h00);
    end
    lock = 1'b0;

    // Default timing, divclk held high, one full frame plus a margin
    reset_dut();
    run_chars(370 * 98 + 150, 100);

    // Zero-coded sync widths and start-address wrap, random divclk
    reset_dut();
    cfg = '{39, 20, 22, 0, 5, 2, 4, 1, 0, 3, 1, 2, 63, 255, 0, 5};
    cfg[10] = ($urandom_range(0, 3) << 5) | 1;
    for (int i = 0; i < 16; i++) wr_reg(i, 8'(cfg[i]));
    run_chars(2 * 26 * 40 + 50, 66);

    // Blink-on-bit4 cursor across 33 short frames
    reset_dut();
    cfg = '{11, 8, 9, 8'h21, 3, 1, 3, 1, 0, 1, 8'h60, 1, 63, 8'hF8, 0, 2};
    for (int i = 0; i < 16; i++) wr_reg(i, 8'(cfg[i]));
    run_chars(33 * 9 * 12 + 20, 66);

    @(negedge clk); #1;
    check("scoreboard drained", 32'(vid_q.size() + rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
